// File: rtl/rtc_pkg.sv
// Shared constants and types for the PCF8563 access scheduler.
package rtc_pkg;

  // PCF8563 register map: seconds start the time block, days start the date block.
  localparam logic [7:0] RegTime = 8'h02;
  localparam logic [7:0] RegDate = 8'h05;

  localparam logic [2:0] LenTime = 3'd3;
  localparam logic [2:0] LenDate = 3'd4;
  localparam logic [2:0] LenRead = 3'd7;

  // BCD field masks; strip VL and century flags from read-back.
  localparam logic [7:0] MaskSec  = 8'h7F;
  localparam logic [7:0] MaskMin  = 8'h7F;
  localparam logic [7:0] MaskHour = 8'h3F;
  localparam logic [7:0] MaskDay  = 8'h3F;
  localparam logic [7:0] MaskWday = 8'h07;
  localparam logic [7:0] MaskMon  = 8'h1F;

  typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;
  typedef enum logic [1:0] {CmdTime, CmdDate, CmdRead} cmd_e;

  // Read bytes in wire order: SS, MM, HH, DD, WW, MON, YY.
  function automatic logic [23:0] unpack_time(input logic [55:0] rd);
    return {rd[23:16] & MaskHour, rd[15:8] & MaskMin, rd[7:0] & MaskSec};
  endfunction

  function automatic logic [31:0] unpack_date(input logic [55:0] rd);
    return {rd[55:48], rd[47:40] & MaskMon, rd[31:24] & MaskDay, rd[39:32] & MaskWday};
  endfunction

  // {YY,MM,DD,WW} -> wire order DD, WW, MM, YY.
  function automatic logic [55:0] pack_date(input logic [31:0] d);
    return {24'h0, d[31:24], d[23:16], d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/rtc_access_sched_if.sv
// Command port between the scheduler and the byte-level I2C master.
interface rtc_access_sched_if;
  logic        i2c_req;
  logic        i2c_rw;
  logic [7:0]  i2c_reg;
  logic [2:0]  i2c_len;
  logic [55:0] i2c_wdata;
  logic        i2c_ack;
  logic        i2c_err;
  logic [55:0] i2c_rdata;

  modport master (
    output i2c_req, i2c_rw, i2c_reg, i2c_len, i2c_wdata,
    input  i2c_ack, i2c_err, i2c_rdata
  );

  modport slave (
    input  i2c_req, i2c_rw, i2c_reg, i2c_len, i2c_wdata,
    output i2c_ack, i2c_err, i2c_rdata
  );
endinterface

// File: rtl/rtc_tick_gen.sv
// Free-running down-counter producing a one-cycle tick every Period cycles.
module rtc_tick_gen #(
  parameter int unsigned Period = 5000000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == '0);

  // Count down, reloading on zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= CntW'(Period - 1);
    end else if (tick) begin
      cnt_q <= CntW'(Period - 1);
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/rtc_access_sched.sv
// Arbitrates time/date writes and periodic read-back onto the single RTC I2C command port.
module rtc_access_sched
  import rtc_pkg::*;
#(
  parameter int unsigned READ_PERIOD = 5000000,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       set_time,
  input  logic [23:0]                time_2_set,
  input  logic                       set_date,
  input  logic [31:0]                date_2_set,
  output logic                       set_done,
  output logic                       set_fail,
  rtc_access_sched_if.master         i2c,
  output logic [23:0]                cur_time,
  output logic [31:0]                cur_date,
  output logic                       rd_valid,
  output logic                       busy,
  output logic [7:0]                 err_cnt
);

  localparam int unsigned TmoW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e              state_q, state_d;
  cmd_e                cmd_q, cmd_d;
  logic [55:0]         wdata_q, wdata_d;
  logic                req_q, req_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                rd_pend_q, rd_pend_d;
  logic                set_done_q, set_done_d;
  logic                set_fail_q, set_fail_d;
  logic                rd_valid_q, rd_valid_d;
  logic [23:0]         cur_time_q, cur_time_d;
  logic [31:0]         cur_date_q, cur_date_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                tick;

  rtc_tick_gen #(
    .Period(READ_PERIOD)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  // Command fields decode from the latched command, so they hold while i2c_req is high.
  assign i2c.i2c_req   = req_q;
  assign i2c.i2c_rw    = (cmd_q == CmdRead);
  assign i2c.i2c_reg   = (cmd_q == CmdDate) ? RegDate : RegTime;
  assign i2c.i2c_len   = (cmd_q == CmdRead) ? LenRead : ((cmd_q == CmdDate) ? LenDate : LenTime);
  assign i2c.i2c_wdata = wdata_q;

  assign set_done = set_done_q;
  assign set_fail = set_fail_q;
  assign rd_valid = rd_valid_q;
  assign cur_time = cur_time_q;
  assign cur_date = cur_date_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = (state_q != StIdle);

  // Arbitration, command handshake, retry and read-back unpack.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    req_d      = req_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    rd_pend_d  = rd_pend_q | tick;
    set_done_d = 1'b0;
    set_fail_d = 1'b0;
    rd_valid_d = 1'b0;
    cur_time_d = cur_time_q;
    cur_date_d = cur_date_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        retry_d = '0;
        if (set_time) begin
          cmd_d   = CmdTime;
          wdata_d = {32'h0, time_2_set};
          state_d = StWait;
        end else if (set_date) begin
          cmd_d   = CmdDate;
          wdata_d = pack_date(date_2_set);
          state_d = StWait;
        end else if (rd_pend_q) begin
          cmd_d     = CmdRead;
          wdata_d   = '0;
          rd_pend_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (!req_q) begin
          // Issue (or re-issue after the one-cycle low) and arm the timeout.
          req_d = 1'b1;
          tmo_d = TmoW'(TIMEOUT - 1);
        end else if (i2c.i2c_ack) begin
          req_d   = 1'b0;
          state_d = StGap;
          if (cmd_q == CmdRead) begin
            cur_time_d = unpack_time(i2c.i2c_rdata);
            cur_date_d = unpack_date(i2c.i2c_rdata);
            rd_valid_d = 1'b1;
          end else begin
            set_done_d = 1'b1;
          end
        end else if (i2c.i2c_err || (tmo_q == '0)) begin
          req_d = 1'b0;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (cmd_q == CmdRead) begin
            state_d = StGap;
          end else if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
          end else begin
            set_done_d = 1'b1;
            set_fail_d = 1'b1;
            state_d    = StGap;
          end
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cmd_q      <= CmdTime;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      tmo_q      <= '0;
      retry_q    <= '0;
      rd_pend_q  <= 1'b0;
      set_done_q <= 1'b0;
      set_fail_q <= 1'b0;
      rd_valid_q <= 1'b0;
      cur_time_q <= '0;
      cur_date_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      rd_pend_q  <= rd_pend_d;
      set_done_q <= set_done_d;
      set_fail_q <= set_fail_d;
      rd_valid_q <= rd_valid_d;
      cur_time_q <= cur_time_d;
      cur_date_q <= cur_date_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
